// File: rtl/system_cpu_jtag_debug_host.sv
// ---------------------------------------------------------------------------
// System CPU JTAG debug host
//
// Runs one virtual-JTAG scan per accepted command. Each scan walks through
// UIR, CDR, DR_WIDTH SDR periods, UDR and RTI. Every period is one generated
// TCK period (TCK low for TCK_DIV clk cycles, then high for TCK_DIV cycles).
// The captured data and IR status are then presented as a response until it
// is consumed.
//
// Ports
//   clk, reset           sole clock (rising edge), async active-high reset
//   cmd_valid/ready      command handshake, accepted only in IDLE
//   cmd_ir, cmd_data     virtual IR value and DR bits (LSB shifted first)
//   rsp_valid/ready      response handshake, held in RSP until consumed
//   rsp_data             bits captured from vji_tdo (bit k from SDR period k)
//   rsp_ir_out           vji_ir_out captured during CDR
//   busy                 high in every state except IDLE
//   vji_tck/tdi/tdo      generated TCK and serial data to/from the target
//   vji_ir_in/ir_out     virtual IR to the target / target IR status
//   vji_rti..vji_udr     virtual JTAG state indications
// ---------------------------------------------------------------------------
module system_cpu_jtag_debug_host #(
   parameter int TCK_DIV  = 2,
   parameter int DR_WIDTH = 38
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_data,
   output logic [1:0]          rsp_ir_out,
   output logic                busy,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [1:0]          vji_ir_in,
   input  logic [1:0]          vji_ir_out,
   output logic                vji_rti,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr
);

   // Divider counts clk cycles within one TCK period, bit counter counts SDR periods
   localparam int DIV_W = $clog2(2 * TCK_DIV);
   localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(TCK_DIV);
   // TCK goes high on the edge that leaves divider value TCK_DIV-1, so the
   // target-side signals are sampled on that same edge
   localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      UIR,
      CDR,
      SDR,
      UDR,
      RTI,
      RSP
   } stateT;

   stateT               state_q,      state_d;
   logic [DIV_W-1:0]    divCnt_q,     divCnt_d;
   logic [BIT_W-1:0]    bitCnt_q,     bitCnt_d;
   logic [1:0]          irIn_q,       irIn_d;
   logic [DR_WIDTH-1:0] cmdShift_q,   cmdShift_d;
   logic [DR_WIDTH-1:0] rspData_q,    rspData_d;
   logic [1:0]          rspIrOut_q,   rspIrOut_d;

   logic inScan;
   logic periodEnd;
   logic tckRise;

   assign inScan    = (state_q == UIR) || (state_q == CDR) || (state_q == SDR) ||
                      (state_q == UDR) || (state_q == RTI);
   assign periodEnd = inScan && (divCnt_q == DIV_LAST);
   assign tckRise   = inScan && (divCnt_q == DIV_RISE);

   // State and datapath registers; reset discards any scan in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         divCnt_q   <= '0;
         bitCnt_q   <= '0;
         irIn_q     <= '0;
         cmdShift_q <= '0;
         rspData_q  <= '0;
         rspIrOut_q <= '0;
      end else begin
         state_q    <= state_d;
         divCnt_q   <= divCnt_d;
         bitCnt_q   <= bitCnt_d;
         irIn_q     <= irIn_d;
         cmdShift_q <= cmdShift_d;
         rspData_q  <= rspData_d;
         rspIrOut_q <= rspIrOut_d;
      end
   end

   // Next-state logic: the divider free-runs through each scan period and the
   // FSM only advances on the last clk cycle of a period. Command data is kept
   // in a shift register so the current TDI bit is always bit 0; response data
   // shifts in from the top so the first captured bit ends up in bit 0.
   always_comb begin
      state_d    = state_q;
      divCnt_d   = divCnt_q;
      bitCnt_d   = bitCnt_q;
      irIn_d     = irIn_q;
      cmdShift_d = cmdShift_q;
      rspData_d  = rspData_q;
      rspIrOut_d = rspIrOut_q;

      if (inScan) begin
         divCnt_d = periodEnd ? '0 : divCnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d    = UIR;
               divCnt_d   = '0;
               bitCnt_d   = '0;
               irIn_d     = cmd_ir;
               cmdShift_d = cmd_data;
            end
         end
         UIR: begin
            if (periodEnd) state_d = CDR;
         end
         CDR: begin
            if (tckRise) rspIrOut_d = vji_ir_out;
            if (periodEnd) state_d = SDR;
         end
         SDR: begin
            if (tckRise) begin
               rspData_d = (rspData_q >> 1) | (DR_WIDTH'(vji_tdo) << (DR_WIDTH - 1));
            end
            if (periodEnd) begin
               cmdShift_d = cmdShift_q >> 1;
               if (bitCnt_q == BIT_LAST) begin
                  state_d = UDR;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end
         end
         UDR: begin
            if (periodEnd) state_d = RTI;
         end
         RTI: begin
            if (periodEnd) state_d = RSP;
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All outputs decode directly from registers so reset forces them at once
   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign rsp_valid  = (state_q == RSP);
   assign rsp_data   = rspData_q;
   assign rsp_ir_out = rspIrOut_q;

   assign vji_tck    = inScan && (divCnt_q >= DIV_HIGH);
   assign vji_tdi    = (state_q == SDR) ? cmdShift_q[0] : 1'b0;
   assign vji_ir_in  = irIn_q;

   assign vji_rti    = (state_q == IDLE) || (state_q == RTI) || (state_q == RSP);
   assign vji_uir    = (state_q == UIR);
   assign vji_cdr    = (state_q == CDR);
   assign vji_sdr    = (state_q == SDR);
   assign vji_udr    = (state_q == UDR);

endmodule

// File: doc/system_cpu_jtag_debug_host.md
SYSTEM_CPU_JTAG_DEBUG_HOST -- requirements
Module: system_cpu_jtag_debug_host

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning clk cycles per TCK half-period; legal values are 1 to 255.
REQ-002 SHALL have parameter DR_WIDTH, default 38, meaning data-register scan length in bits.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  scan request.
- cmd_ready  out  1  request accepted when high with cmd_valid.
- cmd_ir  in  2  virtual IR value for this scan.
- cmd_data  in  DR_WIDTH  bits shifted out on vji_tdi.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed when high with rsp_valid.
- rsp_data  out  DR_WIDTH  bits captured from vji_tdo.
- rsp_ir_out  out  2  vji_ir_out captured during CDR.
- busy  out  1  scan in progress.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to target.
- vji_tdo  in  1  serial data from target.
- vji_ir_in  out  2  virtual IR to target.
- vji_ir_out  in  2  target IR status.
- vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual JTAG state indications.

Function
REQ-004 SHALL implement states IDLE, UIR, CDR, SDR, UDR, RTI, RSP.
REQ-005 SHALL assert cmd_ready only in IDLE and latch cmd_ir and cmd_data on the accepting edge, then enter UIR.
REQ-006 SHALL make every scan state last whole TCK periods of 2*TCK_DIV clk cycles: vji_tck low for the first TCK_DIV cycles, then high for TCK_DIV cycles.
REQ-007 SHALL hold vji_tck low in IDLE and RSP.
REQ-008 SHALL run the sequence UIR (1 period), CDR (1), SDR (DR_WIDTH), UDR (1), RTI (1), RSP.
REQ-009 SHALL assert exactly one of vji_uir/vji_cdr/vji_sdr/vji_udr during its state, held for the whole period; all are 0 in IDLE, RTI and RSP.
REQ-010 SHALL drive vji_rti high in IDLE, RTI and RSP, and low otherwise.
REQ-011 SHALL load vji_ir_in from the latched cmd_ir on entry to UIR and hold it until the next accepted command.
REQ-012 SHALL drive vji_tdi = cmd_data[k] for the whole SDR period k (k = 0 first, LSB first), and 0 outside SDR.
REQ-013 SHALL sample vji_tdo into rsp_data[k] on the clk edge where vji_tck rises in SDR period k.
REQ-014 SHALL sample vji_ir_out into rsp_ir_out on the clk edge where vji_tck rises in CDR.
REQ-015 SHALL assert rsp_valid in RSP exactly (DR_WIDTH+4)*2*TCK_DIV clk cycles after the accepting edge: 168 for the defaults.
REQ-016 SHALL hold rsp_valid, rsp_data and rsp_ir_out stable until rsp_ready, then return to IDLE on that edge.
REQ-017 SHALL ignore cmd_valid outside IDLE and rsp_ready outside RSP.
REQ-018 SHALL assert busy in every state except IDLE.
REQ-019 SHALL use a bit counter wide enough for DR_WIDTH and a divider counter wide enough for TCK_DIV, with no wrap during a legal scan.

Reset
REQ-020 SHALL, while reset is high, force the following regardless of clk:
- state IDLE; vji_tck 0; vji_tdi 0.
- vji_uir/cdr/sdr/udr 0; vji_rti 1; vji_ir_in 0.
- rsp_valid 0; rsp_data 0; rsp_ir_out 0; busy 0; cmd_ready 1.
REQ-021 SHALL discard any scan in progress when reset is asserted, and produce no response for it after release.

Verification
REQ-022 Reset asserted asynchronously mid-cycle -> all REQ-020 values immediately; cmd_ready=1 on first edge after release.
REQ-023 Defaults; target model is a 38-bit shift register preloaded 38'h12_3456_789A, shifting on TCK rise during SDR with tdo=sr[0]; cmd_ir=2'b01, cmd_data=38'h2A_AAA5_5555 ->
- required counts: exactly 38 SDR periods and one each of UIR/CDR/UDR.
- required results: rsp_data=38'h12_3456_789A; model holds 38'h2A_AAA5_5555 at UDR; vji_ir_in=2'b01.
REQ-024 Defaults, accept at cycle 0 -> rsp_valid first high at cycle 168; vji_tck period 4 cycles, 50% duty.
REQ-025 rsp_ready held low 10 cycles with cmd_valid high -> rsp_valid and rsp_data held; cmd_ready=0; second command accepted only on the cycle after rsp_ready handshake.
REQ-026 Reset pulsed during SDR period 20 -> vji_tck=0, vji_sdr=0 at once; no rsp_valid afterwards; a new scan completes normally.
REQ-027 TCK_DIV=1, vji_tdo tied 1, vji_ir_out=2'b10 -> rsp_data=all ones, rsp_ir_out=2'b10, rsp_valid at cycle 84.
